// File: rtl/nanotrade_pkg.sv
// Shared definitions for the nanotrade circuit-breaker path.
//   cb_mode_e     : class / circuit-breaker mode codes; the numeric code is also the severity
//   cb_req_t      : one request (valid, class, confidence)
//   cb_fsm_e      : controller state encoding
//   req_replaces  : pending-slot arbitration (severity, then confidence, newest wins a full tie)
//   req_issuable  : disposition of a request against the book's current mode
package nanotrade_pkg;

    typedef enum logic [1:0] {
        CB_NORMAL   = 2'b00,
        CB_THROTTLE = 2'b01,
        CB_WIDEN    = 2'b10,
        CB_PAUSE    = 2'b11
    } cb_mode_e;

    typedef struct packed {
        logic       valid;
        cb_mode_e   cls;
        logic [7:0] conf;
    } cb_req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_COOL = 2'b10
    } cb_fsm_e;

    // True when severity of a is strictly above severity of b.
    function automatic logic sev_gt(input cb_mode_e a, input cb_mode_e b);
        return a > b;
    endfunction

    // True when cand should take the slot currently holding held.
    function automatic logic req_replaces(input cb_req_t held, input cb_req_t cand);
        if (!held.valid)                return 1'b1;
        if (sev_gt(cand.cls, held.cls)) return 1'b1;
        if (sev_gt(held.cls, cand.cls)) return 1'b0;
        return cand.conf >= held.conf;
    endfunction

    // Release only if something is latched; anomalies never de-escalate the book.
    function automatic logic req_issuable(input cb_mode_e c, input cb_mode_e s);
        if (c == CB_NORMAL) return s != CB_NORMAL;
        return !sev_gt(s, c);
    endfunction

endpackage

// File: rtl/cb_confirm.sv
// Confidence gate and N-of-N debounce for the classifier stream.
//   clk, rst_n    : clock, asynchronous active-low reset
//   ml_valid      : classification strobe
//   ml_class      : class code
//   ml_conf       : classifier confidence
//   req           : confirmed request, valid for the cycle of the confirming strobe
//   fast          : the confirmation came from the high-confidence FLASH_CRASH bypass
module cb_confirm
    import nanotrade_pkg::*;
#(
    parameter int         CONFIRM_N  = 2,
    parameter logic [7:0] CONF_MIN   = 8'd64,
    parameter logic [7:0] CRASH_FAST = 8'd192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ml_valid,
    input  logic [1:0]  ml_class,
    input  logic [7:0]  ml_conf,
    output cb_req_t     req,
    output logic        fast
);

    localparam logic [2:0] N = 3'(CONFIRM_N);

    cb_mode_e   cand_q, cand_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] cnt_inc;
    logic       qual;
    logic       is_fast;
    cb_mode_e   cls;

    assign cls     = cb_mode_e'(ml_class);
    assign qual    = ml_valid && (ml_conf >= CONF_MIN);
    assign is_fast = qual && (cls == CB_PAUSE) && (ml_conf >= CRASH_FAST);
    assign cnt_inc = (cls != cand_q) ? 3'd1 : ((cnt_q >= N) ? N : cnt_q + 3'd1);

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        req    = '0;
        fast   = 1'b0;
        if (ml_valid && !qual) begin
            cnt_d = 3'd0;
        end else if (is_fast) begin
            cand_d = CB_PAUSE;
            cnt_d  = 3'd0;
            req    = '{valid: 1'b1, cls: CB_PAUSE, conf: ml_conf};
            fast   = 1'b1;
        end else if (qual) begin
            cand_d = cls;
            if (cnt_inc == N) begin
                cnt_d = 3'd0;
                req   = '{valid: 1'b1, cls: cls, conf: ml_conf};
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= CB_NORMAL;
            cnt_q  <= 3'd0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/cb_controller.sv
// Circuit-breaker config initiator: turns confirmed classifier requests into
// cb_mode/cb_param/cb_load commands, with post-load cooldown and a one-deep pending slot.
//   clk, rst_n    : clock, asynchronous active-low reset
//   ml_valid      : classification strobe
//   ml_class      : 00 NORMAL, 01 QUOTE_STUFFING, 10 ORDER_IMBALANCE, 11 FLASH_CRASH
//   ml_conf       : classifier confidence
//   cb_state_in   : order book's current breaker mode
//   cb_mode       : mode to latch (held between loads)
//   cb_param      : parameter to latch (held between loads)
//   cb_load       : one-cycle latch strobe
//   pending       : a confirmed request is waiting for cooldown expiry
//   cooldown_act  : cooldown counter nonzero
//   load_count    : saturating count of loads issued
module cb_controller
    import nanotrade_pkg::*;
#(
    parameter int         CONFIRM_N  = 2,
    parameter logic [7:0] CONF_MIN   = 8'd64,
    parameter logic [7:0] CRASH_FAST = 8'd192,
    parameter logic [7:0] COOLDOWN   = 8'd16,
    parameter logic [7:0] PAUSE_MAX  = 8'd200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ml_valid,
    input  logic [1:0]  ml_class,
    input  logic [7:0]  ml_conf,
    input  logic [1:0]  cb_state_in,
    output logic [1:0]  cb_mode,
    output logic [7:0]  cb_param,
    output logic        cb_load,
    output logic        pending,
    output logic        cooldown_act,
    output logic [7:0]  load_count
);

    cb_req_t    conf_req;
    logic       conf_fast;

    cb_confirm #(
        .CONFIRM_N  (CONFIRM_N),
        .CONF_MIN   (CONF_MIN),
        .CRASH_FAST (CRASH_FAST)
    ) u_confirm (
        .clk      (clk),
        .rst_n    (rst_n),
        .ml_valid (ml_valid),
        .ml_class (ml_class),
        .ml_conf  (ml_conf),
        .req      (conf_req),
        .fast     (conf_fast)
    );

    cb_fsm_e    state_q, state_d;
    logic [7:0] cool_q, cool_d;
    cb_req_t    pend_q, pend_d;
    cb_req_t    iss;
    cb_req_t    winner;
    logic       issue;
    cb_mode_e   book;
    logic [7:0] iss_param;

    assign book = cb_mode_e'(cb_state_in);

    always_comb begin
        state_d = state_q;
        cool_d  = (cool_q != 8'd0) ? cool_q - 8'd1 : 8'd0;
        pend_d  = pend_q;
        issue   = 1'b0;
        iss     = conf_req;
        winner  = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                issue = conf_req.valid && req_issuable(conf_req.cls, book);
            end
            ST_LOAD: begin
                // The load cycle already counts as cooldown; a confirm here cannot load next
                // cycle (no back-to-back strobes), so it waits in the slot. The fast path
                // overwrites the slot outright.
                if (COOLDOWN > 8'd1) begin
                    state_d = ST_COOL;
                    if (conf_req.valid && (conf_fast || req_replaces(pend_q, conf_req)))
                        pend_d = conf_req;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COOL: begin
                if (conf_fast) begin
                    issue  = req_issuable(conf_req.cls, book);
                    pend_d = '0;
                end else if (cool_q <= 8'd1) begin
                    // Expiry edge: pending and a same-edge confirmation compete under the slot rules.
                    if (conf_req.valid && req_replaces(pend_q, conf_req))
                        winner = conf_req;
                    pend_d = '0;
                    iss    = winner;
                    issue  = winner.valid && req_issuable(winner.cls, book);
                end else if (conf_req.valid && req_replaces(pend_q, conf_req)) begin
                    pend_d = conf_req;
                end
                if (!issue && cool_d == 8'd0)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (issue) begin
            state_d = ST_LOAD;
            cool_d  = COOLDOWN;
        end
    end

    assign iss_param = (iss.cls == CB_PAUSE && iss.conf > PAUSE_MAX) ? PAUSE_MAX : iss.conf;

    // NOTE: the pending slot is reset in full even though only its valid bit gates behaviour, so its payload never carries X into arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cool_q     <= 8'd0;
            pend_q     <= '0;
            cb_mode    <= 2'b00;
            cb_param   <= 8'd0;
            cb_load    <= 1'b0;
            load_count <= 8'd0;
        end else begin
            state_q <= state_d;
            cool_q  <= cool_d;
            pend_q  <= pend_d;
            cb_load <= issue;
            if (issue) begin
                cb_mode  <= iss.cls;
                cb_param <= iss_param;
                if (load_count != 8'hFF)
                    load_count <= load_count + 8'd1;
            end
        end
    end

    assign pending      = pend_q.valid;
    assign cooldown_act = (cool_q != 8'd0);

endmodule

// File: tb/tb_cb_controller.sv
// Directed bench for cb_controller with default parameters
// (CONFIRM_N=2, CONF_MIN=64, CRASH_FAST=192, COOLDOWN=16, PAUSE_MAX=200).
// Inputs change 1 time unit after a rising edge; outputs are read at that same point.
module tb_cb_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ml_valid;
    logic [1:0] ml_class;
    logic [7:0] ml_conf;
    logic [1:0] cb_state_in;
    logic [1:0] cb_mode;
    logic [7:0] cb_param;
    logic       cb_load;
    logic       pending;
    logic       cooldown_act;
    logic [7:0] load_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cb_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ml_valid     (ml_valid),
        .ml_class     (ml_class),
        .ml_conf      (ml_conf),
        .cb_state_in  (cb_state_in),
        .cb_mode      (cb_mode),
        .cb_param     (cb_param),
        .cb_load      (cb_load),
        .pending      (pending),
        .cooldown_act (cooldown_act),
        .load_count   (load_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [1:0] c, input logic [7:0] p);
        ml_valid = 1'b1;
        ml_class = c;
        ml_conf  = p;
        step();
        ml_valid = 1'b0;
        ml_class = 2'b00;
        ml_conf  = 8'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cooldown_act === 1'b1 && n < 40) begin
            step();
            n++;
        end
        total++;
        if (cooldown_act !== 1'b0) begin
            bad++;
            $display("FAIL cooldown_expire: cooldown_act=%b after %0d cycles, want 0", cooldown_act, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ml_valid = 1'b0; ml_class = 2'b00; ml_conf = 8'd0; cb_state_in = 2'b00;
        #3;
        total++;
        if ({cb_mode, cb_param, cb_load, pending, cooldown_act, load_count} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: mode=%b param=%0d load=%b pend=%b cool=%b cnt=%0d, want all 0",
                     cb_mode, cb_param, cb_load, pending, cooldown_act, load_count);
        end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_qs_confirm();
        cb_state_in = 2'b00;
        strobe(2'b01, 8'd100);
        total++;
        if (cb_load !== 1'b0) begin bad++; $display("FAIL qs_first_no_load: load=%b want 0", cb_load); end
        strobe(2'b01, 8'd100);
        total++;
        if ({cb_load, cb_mode, cb_param, load_count} !== {1'b1, 2'b01, 8'd100, 8'd1}) begin
            bad++;
            $display("FAIL qs_load: load=%b mode=%b param=%0d cnt=%0d want 1/01/100/1", cb_load, cb_mode, cb_param, load_count);
        end
        step();
        total++;
        if ({cb_load, cooldown_act, cb_mode, cb_param} !== {1'b0, 1'b1, 2'b01, 8'd100}) begin
            bad++;
            $display("FAIL qs_after_load: load=%b cool=%b mode=%b param=%0d want 0/1/01/100", cb_load, cooldown_act, cb_mode, cb_param);
        end
        wait_idle();
    endtask

    task automatic test_class_change();
        cb_state_in = 2'b01;
        strobe(2'b01, 8'd100);
        strobe(2'b10, 8'd120);
        total++;
        if (cb_load !== 1'b0) begin bad++; $display("FAIL class_change_no_load: load=%b want 0", cb_load); end
        strobe(2'b10, 8'd120);
        total++;
        if ({cb_load, cb_mode, cb_param, load_count} !== {1'b1, 2'b10, 8'd120, 8'd2}) begin
            bad++;
            $display("FAIL widen_load: load=%b mode=%b param=%0d cnt=%0d want 1/10/120/2", cb_load, cb_mode, cb_param, load_count);
        end
    endtask

    task automatic test_fast_path();
        step();
        cb_state_in = 2'b10;
        total++;
        if (cooldown_act !== 1'b1) begin bad++; $display("FAIL fast_in_cooldown: cool=%b want 1", cooldown_act); end
        strobe(2'b11, 8'd250);
        total++;
        if ({cb_load, cb_mode, cb_param, load_count} !== {1'b1, 2'b11, 8'd200, 8'd3}) begin
            bad++;
            $display("FAIL fast_pause: load=%b mode=%b param=%0d cnt=%0d want 1/11/200/3", cb_load, cb_mode, cb_param, load_count);
        end
        wait_idle();
    endtask

    task automatic test_no_deescalate();
        cb_state_in = 2'b10;
        strobe(2'b01, 8'd100);
        strobe(2'b01, 8'd100);
        total++;
        if ({cb_load, load_count, cb_mode, pending} !== {1'b0, 8'd3, 2'b11, 1'b0}) begin
            bad++;
            $display("FAIL deescalate_drop: load=%b cnt=%0d mode=%b pend=%b want 0/3/11/0", cb_load, load_count, cb_mode, pending);
        end
        cb_state_in = 2'b01;
        strobe(2'b00, 8'd100);
        strobe(2'b00, 8'd100);
        total++;
        if ({cb_load, cb_mode, cb_param, load_count} !== {1'b1, 2'b00, 8'd100, 8'd4}) begin
            bad++;
            $display("FAIL release_load: load=%b mode=%b param=%0d cnt=%0d want 1/00/100/4", cb_load, cb_mode, cb_param, load_count);
        end
        wait_idle();
    endtask

    task automatic test_low_conf();
        cb_state_in = 2'b00;
        strobe(2'b01, 8'd100);
        strobe(2'b01, 8'd30);
        strobe(2'b01, 8'd100);
        total++;
        if (cb_load !== 1'b0) begin bad++; $display("FAIL low_conf_reset: load=%b want 0", cb_load); end
        step();
        strobe(2'b01, 8'd110);
        total++;
        if ({cb_load, cb_mode, cb_param, load_count} !== {1'b1, 2'b01, 8'd110, 8'd5}) begin
            bad++;
            $display("FAIL low_conf_then_load: load=%b mode=%b param=%0d cnt=%0d want 1/01/110/5", cb_load, cb_mode, cb_param, load_count);
        end
    endtask

    task automatic test_pending();
        int n = 0;
        cb_state_in = 2'b01;
        step();
        strobe(2'b10, 8'd90);
        strobe(2'b10, 8'd90);
        total++;
        if ({pending, cb_load, cooldown_act} !== 3'b101) begin
            bad++;
            $display("FAIL pend_store: pend=%b load=%b cool=%b want 1/0/1", pending, cb_load, cooldown_act);
        end
        strobe(2'b01, 8'd200);
        strobe(2'b01, 8'd200);
        total++;
        if ({pending, cb_load} !== 2'b10) begin
            bad++;
            $display("FAIL pend_keep: pend=%b load=%b want 1/0", pending, cb_load);
        end
        while (cb_load !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        total++;
        if (n != 11) begin bad++; $display("FAIL pend_drain_time: waited %0d cycles, want 11", n); end
        total++;
        if ({cb_load, cb_mode, cb_param, pending, load_count} !== {1'b1, 2'b10, 8'd90, 1'b0, 8'd6}) begin
            bad++;
            $display("FAIL pend_drain: load=%b mode=%b param=%0d pend=%b cnt=%0d want 1/10/90/0/6",
                     cb_load, cb_mode, cb_param, pending, load_count);
        end
    endtask

    task automatic test_reset_mid();
        int loads = 0;
        step();
        cb_state_in = 2'b10;
        strobe(2'b10, 8'd80);
        strobe(2'b10, 8'd80);
        strobe(2'b01, 8'd100);
        total++;
        if ({pending, cooldown_act} !== 2'b11) begin
            bad++;
            $display("FAIL mid_setup: pend=%b cool=%b want 1/1", pending, cooldown_act);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({cb_mode, cb_param, cb_load, pending, cooldown_act, load_count} !== 21'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs: mode=%b param=%0d load=%b pend=%b cool=%b cnt=%0d, want all 0",
                     cb_mode, cb_param, cb_load, pending, cooldown_act, load_count);
        end
        cb_state_in = 2'b00;
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (cb_load === 1'b1) loads++;
        end
        total++;
        if (loads != 0) begin bad++; $display("FAIL post_reset_quiet: saw %0d loads, want 0", loads); end
        strobe(2'b01, 8'd100);
        total++;
        if ({cb_load, load_count} !== {1'b0, 8'd0}) begin
            bad++;
            $display("FAIL debounce_cleared: load=%b cnt=%0d want 0/0", cb_load, load_count);
        end
    endtask

    initial begin
        test_reset();
        test_qs_confirm();
        test_class_change();
        test_fast_path();
        test_no_deescalate();
        test_low_conf();
        test_pending();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
